// File: rtl/phase_cycle_sequencer_pkg.sv
// phase_cycle_sequencer_pkg: shared widths, phase codes and FSM states for the phase sequencer
package phase_cycle_sequencer_pkg;
  localparam int DEF_PHASE_W = 2;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_SCAN_W = 16;
  localparam logic [1:0] PHASE_0 = 2'd0;
  localparam logic [1:0] PHASE_90 = 2'd1;
  localparam logic [1:0] PHASE_180 = 2'd2;
  localparam logic [1:0] PHASE_270 = 2'd3;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, FIN} state_t;
endpackage

// File: rtl/phase_table_ram.sv
// phase_table_ram: phase-cycling table with sync write, registered read and async clear
module phase_table_ram #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/phase_cycle_sequencer.sv
// phase_cycle_sequencer: steps a phase-cycling table once per scan and drives TX/RX phases
module phase_cycle_sequencer
  import phase_cycle_sequencer_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SCAN_W = DEF_SCAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tbl_we,
  input  logic [ADDR_W-1:0]    tbl_addr,
  input  logic [2*PHASE_W-1:0] tbl_data,
  input  logic [ADDR_W:0]      n_steps,
  input  logic [SCAN_W-1:0]    n_scans,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 scan_done,
  output logic [PHASE_W-1:0]   TX_phase,
  output logic [PHASE_W-1:0]   RX_phase,
  output logic                 phases_valid,
  output logic [ADDR_W-1:0]    step_idx,
  output logic [SCAN_W-1:0]    scan_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 seq_err
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t state;
  logic [ADDR_W:0] steps_q, steps_clamp, step_nxt;
  logic [SCAN_W-1:0] scans_q, cnt_nxt;
  logic [2*PHASE_W-1:0] rdata;
  assign steps_clamp = (n_steps == '0) ? ONE : (n_steps > DEPTH) ? DEPTH : n_steps;
  assign step_nxt = {1'b0, step_idx} + 1'b1;
  assign cnt_nxt = scan_cnt + 1'b1;
  assign TX_phase = rdata[PHASE_W-1:0];
  assign RX_phase = rdata[2*PHASE_W-1:PHASE_W];
  phase_table_ram #(.AW(ADDR_W), .DW(2*PHASE_W)) u_tbl (
    .clk(clk),
    .rst_n(rst_n),
    .we(tbl_we & ~busy),
    .waddr(tbl_addr),
    .wdata(tbl_data),
    .re(state == LOAD),
    .raddr(step_idx),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      steps_q <= '0;
      scans_q <= '0;
      step_idx <= '0;
      scan_cnt <= '0;
      phases_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        phases_valid <= 1'b0;
        busy <= 1'b0;
      end else case (state)
        IDLE: if (start) begin
          steps_q <= steps_clamp;
          scans_q <= n_scans;
          step_idx <= '0;
          scan_cnt <= '0;
          seq_err <= 1'b0;
          busy <= 1'b1;
          state <= (n_scans == '0) ? FIN : LOAD;
        end
        LOAD: begin
          phases_valid <= 1'b1;
          state <= ACTIVE;
          if (scan_done) seq_err <= 1'b1;
        end
        ACTIVE: if (scan_done) begin
          scan_cnt <= cnt_nxt;
          phases_valid <= 1'b0;
          state <= (cnt_nxt == scans_q) ? FIN : LOAD;
          if (cnt_nxt != scans_q) step_idx <= (step_nxt == steps_q) ? '0 : step_nxt[ADDR_W-1:0];
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
          if (scan_done) seq_err <= 1'b1;
        end
      endcase
    end
endmodule
